osd_ring_station: RTL and testbench

- Parametrised debug-ring station that attaches PORTS local DII endpoints to one ring segment.
- Replaces fixed-port ring wiring with address-based routing.
  - Ring packets addressed to the station's ID range are ejected to the matching local port.
  - All other ring packets are forwarded downstream.
- Local packets are injected onto the ring under packet-atomic round-robin arbitration.
- Ring output is registered, so stations chain with one cycle per hop.

---
 rtl/osd_ring_station.sv | 254 +++++++++++++++++++++++++
 tb/tb_osd_ring_station.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_ring_station.sv
// ---------------------------------------------------------------------------
// osd_ring_station
//   Debug-ring station that attaches PORTS local DII endpoints to one ring
//   segment. Ring packets whose destination ID (data[15:0] of the first
//   flit) falls in [BASE_ID, BASE_ID+PORTS-1] are ejected to the matching
//   local port with zero added latency. All other ring packets and all
//   local packets are merged onto the downstream ring. The merge uses a
//   packet-atomic round-robin arbiter (source 0 = ring-through, source i+1 =
//   local port i) feeding a one-entry output register.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ring_in_*  (data/first/last/valid -> ready)    upstream ring
//   ring_out_* (data/first/last/valid <- ready)    downstream ring, registered
//   local_in_*  [PORTS]  endpoint -> station, data flattened at [i*WIDTH +: WIDTH]
//   local_out_* [PORTS]  station -> endpoint, data flattened the same way
//
// Optional feature (macro OSD_RING_STATION_STATS_EN)
//   Adds stat_fwd_pkts / stat_eject_pkts saturating packet counters.
// ---------------------------------------------------------------------------
module osd_ring_station #(
    parameter int PORTS   = 2,
    parameter int BASE_ID = 0,
    parameter int WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       ring_in_data,
    input  logic                   ring_in_first,
    input  logic                   ring_in_last,
    input  logic                   ring_in_valid,
    output logic                   ring_in_ready,
    output logic [WIDTH-1:0]       ring_out_data,
    output logic                   ring_out_first,
    output logic                   ring_out_last,
    output logic                   ring_out_valid,
    input  logic                   ring_out_ready,
    input  logic [PORTS*WIDTH-1:0] local_in_data,
    input  logic [PORTS-1:0]       local_in_first,
    input  logic [PORTS-1:0]       local_in_last,
    input  logic [PORTS-1:0]       local_in_valid,
    output logic [PORTS-1:0]       local_in_ready,
    output logic [PORTS*WIDTH-1:0] local_out_data,
    output logic [PORTS-1:0]       local_out_first,
    output logic [PORTS-1:0]       local_out_last,
    output logic [PORTS-1:0]       local_out_valid,
    input  logic [PORTS-1:0]       local_out_ready
`ifdef OSD_RING_STATION_STATS_EN
    ,
    output logic [15:0]            stat_fwd_pkts,
    output logic [15:0]            stat_eject_pkts
`endif
);

    localparam int NSRC = PORTS + 1;
    localparam int SW   = $clog2(NSRC);
    localparam int PW   = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {IN_IDLE, IN_EJECT, IN_FWD} in_state_t;
    typedef enum logic       {ARB_IDLE, ARB_BUSY}        arb_state_t;

    // ---------------- ingress routing ----------------
    in_state_t     in_state_q, in_state_d;
    logic [PW-1:0] eject_port_q, eject_port_d;
    logic [15:0]   dest;
    logic          dest_hit;
    logic          route_eject;
    logic [PW-1:0] route_port;
    logic          ring_hs;

    assign dest     = ring_in_data[15:0];
    assign dest_hit = (int'(dest) >= BASE_ID) && (int'(dest) < BASE_ID + PORTS);

    // The route is decided from the first flit while idle and then held in
    // state, so body flits need no address decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        route_eject = 1'b0;
        route_port  = eject_port_q;
        case (in_state_q)
            IN_IDLE: begin
                if (ring_in_first && dest_hit) begin
                    route_eject = 1'b1;
                    route_port  = PW'(int'(dest) - BASE_ID);
                end
            end
            IN_EJECT: route_eject = 1'b1;
            default:  route_eject = 1'b0;
        endcase
    end

    // ---------------- egress arbitration ----------------
    arb_state_t     arb_q, arb_d;
    logic [SW-1:0]  gnt_q, gnt_d, rr_q, rr_d;
    logic [NSRC-1:0] src_valid, src_req, src_first, src_last;
    logic [WIDTH-1:0] src_data [NSRC];
    logic           srch_found;
    logic [SW-1:0]  srch_idx;
    int             cand;
    logic           gnt_valid;
    logic [SW-1:0]  gnt_idx;
    logic           sel_valid, sel_first, sel_last;
    logic [WIDTH-1:0] sel_data;
    logic           src_ready;
    logic           xfer;

    always_comb begin
        src_valid[0] = ring_in_valid && !route_eject;
        src_req[0]   = ring_in_valid && !route_eject;
        src_first[0] = ring_in_first;
        src_last[0]  = ring_in_last;
        src_data[0]  = ring_in_data;
        for (int i = 0; i < PORTS; i++) begin
            src_valid[i+1] = local_in_valid[i];
            // Local packets only compete for the ring at a packet start.
            src_req[i+1]   = local_in_valid[i] && local_in_first[i];
            src_first[i+1] = local_in_first[i];
            src_last[i+1]  = local_in_last[i];
            src_data[i+1]  = local_in_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first requester at or after rr_q, wrapping.
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NSRC; k++) begin
            cand = (int'(rr_q) + k) % NSRC;
            if (!srch_found && src_req[SW'(cand)]) begin
                srch_found = 1'b1;
                srch_idx   = SW'(cand);
            end
        end
    end

    assign gnt_valid = (arb_q == ARB_BUSY) || srch_found;
    assign gnt_idx   = (arb_q == ARB_BUSY) ? gnt_q : srch_idx;
    assign sel_valid = gnt_valid && src_valid[gnt_idx];
    assign sel_first = src_first[gnt_idx];
    assign sel_last  = src_last[gnt_idx];
    assign sel_data  = src_data[gnt_idx];
    assign src_ready = !ring_out_valid || ring_out_ready;
    assign xfer      = !rst && sel_valid && src_ready;

    // ---------------- handshake outputs ----------------
    always_comb begin
        ring_in_ready = 1'b0;
        if (!rst) begin
            if (route_eject) begin
                for (int i = 0; i < PORTS; i++)
                    if (route_port == PW'(i)) ring_in_ready = local_out_ready[i];
            end else begin
                ring_in_ready = gnt_valid && (gnt_idx == '0) && src_ready;
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            local_in_ready[i]  = !rst && gnt_valid && (gnt_idx == SW'(i + 1)) && src_ready;
            local_out_valid[i] = !rst && ring_in_valid && route_eject && (route_port == PW'(i));
        end
    end

    // Data and framing are broadcast; only the selected port sees valid.
    assign local_out_data  = {PORTS{ring_in_data}};
    assign local_out_first = {PORTS{ring_in_first}};
    assign local_out_last  = {PORTS{ring_in_last}};

    assign ring_hs = ring_in_valid && ring_in_ready;

    // ---------------- next-state logic ----------------
    always_comb begin
        in_state_d   = in_state_q;
        eject_port_d = eject_port_q;
        case (in_state_q)
            IN_IDLE: begin
                // Single-flit packets and stray body flits stay in IDLE.
                if (ring_hs && ring_in_first && !ring_in_last) begin
                    in_state_d   = route_eject ? IN_EJECT : IN_FWD;
                    eject_port_d = route_port;
                end
            end
            default: begin
                if (ring_hs && ring_in_last) in_state_d = IN_IDLE;
            end
        endcase
    end

    always_comb begin
        arb_d = arb_q;
        gnt_d = gnt_q;
        rr_d  = rr_q;
        if (xfer) begin
            if (sel_last) begin
                arb_d = ARB_IDLE;
                rr_d  = (gnt_idx == SW'(PORTS)) ? '0 : gnt_idx + SW'(1);
            end else begin
                arb_d = ARB_BUSY;
                gnt_d = gnt_idx;
            end
        end
    end

    // ---------------- state and output register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q     <= IN_IDLE;
            eject_port_q   <= '0;
            arb_q          <= ARB_IDLE;
            gnt_q          <= '0;
            rr_q           <= '0;
            ring_out_valid <= 1'b0;
            ring_out_first <= 1'b0;
            ring_out_last  <= 1'b0;
            ring_out_data  <= '0;
        end else begin
            in_state_q   <= in_state_d;
            eject_port_q <= eject_port_d;
            arb_q        <= arb_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            if (xfer) begin
                ring_out_valid <= 1'b1;
                ring_out_first <= sel_first;
                ring_out_last  <= sel_last;
                ring_out_data  <= sel_data;
            end else if (ring_out_ready) begin
                ring_out_valid <= 1'b0;
            end
        end
    end

`ifdef OSD_RING_STATION_STATS_EN
    // Packet counters, saturating at 0xFFFF.
    logic fwd_done, eject_done;
    assign fwd_done   = xfer && (gnt_idx == '0) && sel_last;
    assign eject_done = ring_hs && route_eject && ring_in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fwd_pkts   <= '0;
            stat_eject_pkts <= '0;
        end else begin
            if (fwd_done && stat_fwd_pkts != 16'hFFFF)
                stat_fwd_pkts <= stat_fwd_pkts + 16'd1;
            if (eject_done && stat_eject_pkts != 16'hFFFF)
                stat_eject_pkts <= stat_eject_pkts + 16'd1;
        end
    end
`else
    // Statistics counters are not built; routing is unaffected.
`endif

endmodule

// File: tb/tb_osd_ring_station.sv
// ---------------------------------------------------------------------------
// tb_osd_ring_station
//   Directed bench for osd_ring_station (PORTS=2, BASE_ID=4, WIDTH=16).
//   Expected flits are queued per output when stimulus is issued and popped
//   by negedge monitors whenever an output handshake is about to happen.
// ---------------------------------------------------------------------------
module tb_osd_ring_station;

    localparam int PORTS   = 2;
    localparam int BASE_ID = 4;
    localparam int WIDTH   = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [WIDTH-1:0]       ring_in_data = '0;
    logic                   ring_in_first = 1'b0;
    logic                   ring_in_last = 1'b0;
    logic                   ring_in_valid = 1'b0;
    logic                   ring_in_ready;
    logic [WIDTH-1:0]       ring_out_data;
    logic                   ring_out_first;
    logic                   ring_out_last;
    logic                   ring_out_valid;
    logic                   ring_out_ready = 1'b1;
    logic [PORTS*WIDTH-1:0] local_in_data = '0;
    logic [PORTS-1:0]       local_in_first = '0;
    logic [PORTS-1:0]       local_in_last = '0;
    logic [PORTS-1:0]       local_in_valid = '0;
    logic [PORTS-1:0]       local_in_ready;
    logic [PORTS*WIDTH-1:0] local_out_data;
    logic [PORTS-1:0]       local_out_first;
    logic [PORTS-1:0]       local_out_last;
    logic [PORTS-1:0]       local_out_valid;
    logic [PORTS-1:0]       local_out_ready = '1;
`ifdef OSD_RING_STATION_STATS_EN
    logic [15:0]            stat_fwd_pkts;
    logic [15:0]            stat_eject_pkts;
`endif

    osd_ring_station #(.PORTS(PORTS), .BASE_ID(BASE_ID), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .ring_in_data    (ring_in_data),
        .ring_in_first   (ring_in_first),
        .ring_in_last    (ring_in_last),
        .ring_in_valid   (ring_in_valid),
        .ring_in_ready   (ring_in_ready),
        .ring_out_data   (ring_out_data),
        .ring_out_first  (ring_out_first),
        .ring_out_last   (ring_out_last),
        .ring_out_valid  (ring_out_valid),
        .ring_out_ready  (ring_out_ready),
        .local_in_data   (local_in_data),
        .local_in_first  (local_in_first),
        .local_in_last   (local_in_last),
        .local_in_valid  (local_in_valid),
        .local_in_ready  (local_in_ready),
        .local_out_data  (local_out_data),
        .local_out_first (local_out_first),
        .local_out_last  (local_out_last),
        .local_out_valid (local_out_valid),
        .local_out_ready (local_out_ready)
`ifdef OSD_RING_STATION_STATS_EN
        ,
        .stat_fwd_pkts   (stat_fwd_pkts),
        .stat_eject_pkts (stat_eject_pkts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             first;
        logic             last;
    } flit_t;

    flit_t ring_q[$];
    flit_t loc_q[PORTS][$];
    flit_t mon_e;
    bit    mon_en = 1'b1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_ring(input logic [15:0] d, input logic f, input logic l);
        ring_q.push_back(flit_t'({d, f, l}));
    endfunction

    function automatic void exp_local(input int p, input logic [15:0] d, input logic f, input logic l);
        loc_q[p].push_back(flit_t'({d, f, l}));
    endfunction

    // Output monitors: a handshake completes at the next posedge whenever
    // valid && ready is seen here, since stimulus only moves just after posedge.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (ring_out_valid && ring_out_ready) begin
                if (ring_q.size() == 0) begin
                    check("ring_out_extra_flit", 32'(ring_q.size()), 32'd1);
                end else begin
                    mon_e = ring_q.pop_front();
                    check("ring_out_data",  32'(ring_out_data),  32'(mon_e.data));
                    check("ring_out_first", 32'(ring_out_first), 32'(mon_e.first));
                    check("ring_out_last",  32'(ring_out_last),  32'(mon_e.last));
                end
            end
            for (int p = 0; p < PORTS; p++) begin
                if (local_out_valid[p] && local_out_ready[p]) begin
                    if (loc_q[p].size() == 0) begin
                        check($sformatf("local_out%0d_extra_flit", p), 32'(loc_q[p].size()), 32'd1);
                    end else begin
                        mon_e = loc_q[p].pop_front();
                        check($sformatf("local_out%0d_data", p),  32'(local_out_data[p*WIDTH +: WIDTH]), 32'(mon_e.data));
                        check($sformatf("local_out%0d_first", p), 32'(local_out_first[p]), 32'(mon_e.first));
                        check($sformatf("local_out%0d_last", p),  32'(local_out_last[p]),  32'(mon_e.last));
                    end
                end
            end
        end
    end

    // Drive one ring flit until accepted (bounded). eject_port >= 0 checks
    // the zero-latency ejection; chk_fwd checks ring_out one cycle later.
    task automatic ring_send(input logic [15:0] d, input logic f, input logic l,
                             input int eject_port, input bit chk_fwd);
        bit hs = 1'b0;
        ring_in_data  = d;
        ring_in_first = f;
        ring_in_last  = l;
        ring_in_valid = 1'b1;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = ring_in_valid && ring_in_ready;
            if (hs && eject_port >= 0) begin
                check("eject_same_cycle_valid", 32'(local_out_valid[eject_port]), 32'd1);
                check("eject_same_cycle_data",  32'(local_out_data[eject_port*WIDTH +: WIDTH]), 32'(d));
            end
            @(posedge clk); #1;
        end
        check("ring_in_accepted", 32'(hs), 32'd1);
        ring_in_valid = 1'b0;
        if (chk_fwd) begin
            check("fwd_latency_valid", 32'(ring_out_valid), 32'd1);
            check("fwd_latency_data",  32'(ring_out_data),  32'(d));
        end
    endtask

    task automatic local_send(input int p, input logic [15:0] d, input logic f, input logic l);
        bit hs = 1'b0;
        local_in_data[p*WIDTH +: WIDTH] = d;
        local_in_first[p] = f;
        local_in_last[p]  = l;
        local_in_valid[p] = 1'b1;
        for (int n = 0; n < 200 && !hs; n++) begin
            @(negedge clk);
            hs = local_in_valid[p] && local_in_ready[p];
            @(posedge clk); #1;
        end
        check($sformatf("local_in%0d_accepted", p), 32'(hs), 32'd1);
        local_in_valid[p] = 1'b0;
    endtask

    logic [15:0] hold_d;
    logic        hold_f, hold_l;
    bit          seen;

    initial begin
        // ---- reset with every input asserting valid ----
        ring_in_valid  = 1'b1;
        ring_in_first  = 1'b1;
        ring_in_last   = 1'b1;
        ring_in_data   = 16'h0009;
        local_in_valid = '1;
        local_in_first = '1;
        local_in_last  = '1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ring_out_valid",  32'(ring_out_valid),  32'd0);
            check("rst_local_out_valid", 32'(local_out_valid), 32'd0);
            check("rst_ring_in_ready",   32'(ring_in_ready),   32'd0);
            check("rst_local_in_ready",  32'(local_in_ready),  32'd0);
        end
        @(posedge clk); #1;
        rst            = 1'b0;
        local_in_valid = '0;
        ring_in_data   = 16'h0004;          // single-flit packet for port 0
        exp_local(0, 16'h0004, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_ring_in_ready", 32'(ring_in_ready), 32'd1);
        @(posedge clk); #1;
        ring_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- eject a 3-flit packet to port 1 ----
        exp_local(1, 16'h0005, 1'b1, 1'b0);
        exp_local(1, 16'h1234, 1'b0, 1'b0);
        exp_local(1, 16'hBEEF, 1'b0, 1'b1);
        ring_send(16'h0005, 1'b1, 1'b0, 1, 1'b0);
        ring_send(16'h1234, 1'b0, 1'b0, 1, 1'b0);
        ring_send(16'hBEEF, 1'b0, 1'b1, 1, 1'b0);
        @(negedge clk);
        check("eject_ring_out_idle", 32'(ring_out_valid), 32'd0);
        @(posedge clk); #1;

        // ---- forward a 3-flit packet ----
        exp_ring(16'h0009, 1'b1, 1'b0);
        exp_ring(16'h0001, 1'b0, 1'b0);
        exp_ring(16'hCAFE, 1'b0, 1'b1);
        ring_send(16'h0009, 1'b1, 1'b0, -1, 1'b1);
        ring_send(16'h0001, 1'b0, 1'b0, -1, 1'b1);
        ring_send(16'hCAFE, 1'b0, 1'b1, -1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // ---- port0 and port1 request together; rr pointer is now 1 ----
        exp_ring(16'h0100, 1'b1, 1'b0);
        exp_ring(16'h0101, 1'b0, 1'b1);
        exp_ring(16'h0200, 1'b1, 1'b0);
        exp_ring(16'h0201, 1'b0, 1'b1);
        fork
            begin
                local_send(0, 16'h0100, 1'b1, 1'b0);
                local_send(0, 16'h0101, 1'b0, 1'b1);
            end
            begin
                local_send(1, 16'h0200, 1'b1, 1'b0);
                local_send(1, 16'h0201, 1'b0, 1'b1);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // ---- ring and port0 together; rr pointer wrapped to ring ----
        exp_ring(16'h000C, 1'b1, 1'b0);
        exp_ring(16'h0C01, 1'b0, 1'b1);
        exp_ring(16'h0300, 1'b1, 1'b0);
        exp_ring(16'h0301, 1'b0, 1'b1);
        fork
            begin
                ring_send(16'h000C, 1'b1, 1'b0, -1, 1'b0);
                ring_send(16'h0C01, 1'b0, 1'b1, -1, 1'b0);
            end
            begin
                local_send(0, 16'h0300, 1'b1, 1'b0);
                local_send(0, 16'h0301, 1'b0, 1'b1);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // ---- downstream backpressure for 5 cycles mid-packet ----
        exp_ring(16'h000A, 1'b1, 1'b0);
        exp_ring(16'h0A01, 1'b0, 1'b0);
        exp_ring(16'h0A02, 1'b0, 1'b0);
        exp_ring(16'h0A03, 1'b0, 1'b1);
        fork
            begin
                ring_send(16'h000A, 1'b1, 1'b0, -1, 1'b0);
                ring_send(16'h0A01, 1'b0, 1'b0, -1, 1'b0);
                ring_send(16'h0A02, 1'b0, 1'b0, -1, 1'b0);
                ring_send(16'h0A03, 1'b0, 1'b1, -1, 1'b0);
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 100 && !seen; n++) begin
                    @(posedge clk); #1;
                    seen = ring_out_valid && (ring_out_data == 16'h0A01);
                end
                check("bp_flit_reached_output", 32'(seen), 32'd1);
                ring_out_ready = 1'b0;
                hold_d = ring_out_data;
                hold_f = ring_out_first;
                hold_l = ring_out_last;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_valid",   32'(ring_out_valid), 32'd1);
                    check("bp_hold_data",    32'(ring_out_data),  32'(hold_d));
                    check("bp_hold_first",   32'(ring_out_first), 32'(hold_f));
                    check("bp_hold_last",    32'(ring_out_last),  32'(hold_l));
                    check("bp_upstream_stall", 32'(ring_in_ready), 32'd0);
                end
                @(posedge clk); #1;
                ring_out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

`ifdef OSD_RING_STATION_STATS_EN
        // ---- statistics: 3 forwarded, 2 ejected, then saturation ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_ring(16'h0009, 1'b1, 1'b1);
            ring_send(16'h0009, 1'b1, 1'b1, -1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            exp_local(0, 16'h0004, 1'b1, 1'b1);
            ring_send(16'h0004, 1'b1, 1'b1, 0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("stat_fwd_pkts_3",   32'(stat_fwd_pkts),   32'd3);
        check("stat_eject_pkts_2", 32'(stat_eject_pkts), 32'd2);
        mon_en        = 1'b0;
        ring_in_data  = 16'h0009;
        ring_in_first = 1'b1;
        ring_in_last  = 1'b1;
        ring_in_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        ring_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stat_fwd_pkts_sat",   32'(stat_fwd_pkts),   32'h0000FFFF);
        check("stat_eject_pkts_hold", 32'(stat_eject_pkts), 32'd2);
        mon_en = 1'b1;
`endif

        // ---- every expected flit must have appeared ----
        repeat (3) @(posedge clk);
        #1;
        check("ring_q_drained",   32'(ring_q.size()),   32'd0);
        check("local0_q_drained", 32'(loc_q[0].size()), 32'd0);
        check("local1_q_drained", 32'(loc_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
